// File: rtl/packet_tx_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | packet_tx_arbiter_pkg : frame constants, state codes, length helper |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package packet_tx_arbiter_pkg;

    localparam logic [7:0] C_SYNC0      = 8'hA5;
    localparam logic [7:0] C_SYNC1      = 8'h5A;
    localparam logic [7:0] C_TYPE_CALIB = 8'h01;
    localparam logic [7:0] C_TYPE_DIST  = 8'h02;

    localparam logic [2:0] C_ST_IDLE = 3'd0;
    localparam logic [2:0] C_ST_HDR  = 3'd1;
    localparam logic [2:0] C_ST_RD   = 3'd2;
    localparam logic [2:0] C_ST_PAY  = 3'd3;
    localparam logic [2:0] C_ST_SUM  = 3'd4;
    localparam logic [2:0] C_ST_DONE = 3'd5;

    localparam logic C_SRC_CALIB = 1'b0;
    localparam logic C_SRC_DIST  = 1'b1;

    typedef struct packed {
        logic        bank;
        logic [15:0] points;
    } req_slot_t;

    // Product kept at 17 bits, then clamped to one RAM bank.
    function automatic logic [15:0] payload_len(input logic [15:0] points,
                                                input int unsigned bpd,
                                                input int unsigned max_bytes);
        logic [16:0] len17;
        len17 = 17'(32'(points) * bpd);
        if (32'(len17) > max_bytes) return 16'(max_bytes);
        return len17[15:0];
    endfunction

    function automatic logic [7:0] hdr_byte(input logic [2:0] k,
                                            input logic [7:0] typ,
                                            input logic [15:0] len);
        case (k)
            3'd0:    return C_SYNC0;
            3'd1:    return C_SYNC1;
            3'd2:    return typ;
            3'd3:    return len[15:8];
            default: return len[7:0];
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/packet_tx_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | packet_tx_arbiter_if : valid/ready byte stream                     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface packet_tx_arbiter_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/packet_tx_arbiter_req_slot.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pkt_req_slot : pending flag, request slot and overrun pulse        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pkt_req_slot
    import packet_tx_arbiter_pkg::*;
(
    input  wire logic        i_clk,
    input  wire logic        i_rst_n,
    input  wire logic        i_make,
    input  wire logic        i_bank,
    input  wire logic [15:0] i_points,
    input  wire logic        i_grant,
    output      logic        o_pending,
    output      req_slot_t   o_slot,
    output      logic        o_overrun
);
    logic      pending_q, pending_d;
    logic      overrun_q, overrun_d;
    req_slot_t slot_q, slot_d;

    // A make arriving with the grant re-arms the slot; that is not an overrun.
    always_comb begin
        pending_d = i_make | (pending_q & ~i_grant);
        overrun_d = i_make & pending_q & ~i_grant;
        slot_d    = slot_q;
        if (i_make) slot_d = '{bank: i_bank, points: i_points};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            slot_q    <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            slot_q    <= slot_d;
        end
    end

    assign o_pending = pending_q;
    assign o_slot    = slot_q;
    assign o_overrun = overrun_q;
endmodule
`default_nettype wire

// File: rtl/packet_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | packet_tx_arbiter : two-source RAM-to-stream packet framer         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module packet_tx_arbiter
    import packet_tx_arbiter_pkg::*;
#(
    parameter int unsigned CALIB_BPD = 8,
    parameter int unsigned DIST_BPD  = 4,
    parameter int unsigned MAX_BYTES = 1024
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst_n,
    input  wire logic        i_calib_make,
    input  wire logic        i_calib_pingpang,
    input  wire logic [15:0] i_calib_points,
    input  wire logic        i_dist_make,
    input  wire logic        i_dist_pingpang,
    input  wire logic [15:0] i_dist_points,
    output      logic [10:0] o_calib_rdaddr,
    input  wire logic [7:0]  i_calib_rddata,
    output      logic [10:0] o_dist_rdaddr,
    input  wire logic [7:0]  i_dist_rddata,
    packet_tx_arbiter_if.master tx_if,
    output      logic        o_busy,
    output      logic [1:0]  o_overrun
);
    logic      w_calib_pend, w_dist_pend, w_calib_ovr, w_dist_ovr;
    req_slot_t w_calib_slot, w_dist_slot, w_win_slot;
    logic      w_grant_calib, w_grant_dist, w_accept;
    logic [15:0] w_win_len;
    logic [7:0]  w_type, w_win_type, w_rddata;

    logic [2:0]  state_q, state_d;
    logic        src_q, src_d, bank_q, bank_d, last_q, last_d;
    logic [15:0] len_q, len_d;
    logic [10:0] idx_q, idx_d;
    logic [9:0]  addr_q, addr_d;
    logic [2:0]  hdr_idx_q, hdr_idx_d;
    logic [7:0]  csum_q, csum_d, tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;

    pkt_req_slot u_calib_slot (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_make(i_calib_make),
        .i_bank(i_calib_pingpang), .i_points(i_calib_points), .i_grant(w_grant_calib),
        .o_pending(w_calib_pend), .o_slot(w_calib_slot), .o_overrun(w_calib_ovr)
    );

    pkt_req_slot u_dist_slot (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_make(i_dist_make),
        .i_bank(i_dist_pingpang), .i_points(i_dist_points), .i_grant(w_grant_dist),
        .o_pending(w_dist_pend), .o_slot(w_dist_slot), .o_overrun(w_dist_ovr)
    );

    // On a tie the source that did not go last wins.
    always_comb begin
        w_grant_calib = 1'b0;
        w_grant_dist  = 1'b0;
        if (state_q == C_ST_IDLE) begin
            if (w_calib_pend && (!w_dist_pend || last_q == C_SRC_DIST)) w_grant_calib = 1'b1;
            else if (w_dist_pend)                                        w_grant_dist  = 1'b1;
        end
    end

    assign w_win_slot = w_grant_calib ? w_calib_slot : w_dist_slot;
    assign w_win_type = w_grant_calib ? C_TYPE_CALIB : C_TYPE_DIST;
    assign w_win_len  = w_grant_calib ? payload_len(w_calib_slot.points, CALIB_BPD, MAX_BYTES)
                                      : payload_len(w_dist_slot.points, DIST_BPD, MAX_BYTES);
    assign w_type     = (src_q == C_SRC_DIST) ? C_TYPE_DIST : C_TYPE_CALIB;
    assign w_rddata   = (src_q == C_SRC_DIST) ? i_dist_rddata : i_calib_rddata;
    assign w_accept   = tx_valid_q & tx_if.tx_ready;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        bank_d     = bank_q;
        last_d     = last_q;
        len_d      = len_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        hdr_idx_d  = hdr_idx_q;
        csum_d     = csum_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        case (state_q)
            C_ST_IDLE: begin
                if (w_grant_calib || w_grant_dist) begin
                    state_d    = C_ST_HDR;
                    src_d      = w_grant_dist;
                    bank_d     = w_win_slot.bank;
                    len_d      = w_win_len;
                    idx_d      = '0;
                    addr_d     = '0;
                    hdr_idx_d  = '0;
                    csum_d     = w_win_type ^ w_win_len[15:8] ^ w_win_len[7:0];
                    tx_valid_d = 1'b1;
                    tx_data_d  = C_SYNC0;
                end
            end
            C_ST_HDR: begin
                if (w_accept) begin
                    if (hdr_idx_q != 3'd4) begin
                        hdr_idx_d = hdr_idx_q + 3'd1;
                        tx_data_d = hdr_byte(hdr_idx_q + 3'd1, w_type, len_q);
                    end else if (len_q == 16'd0) begin
                        state_d   = C_ST_SUM;
                        tx_data_d = csum_q;
                    end else begin
                        state_d    = C_ST_RD;
                        tx_valid_d = 1'b0;
                    end
                end
            end
            C_ST_RD: state_d = C_ST_PAY;
            C_ST_PAY: begin
                // First PAY cycle captures the RAM word issued during RD.
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = w_rddata;
                    csum_d     = csum_q ^ w_rddata;
                end else if (w_accept) begin
                    if ({5'd0, idx_q} == len_q - 16'd1) begin
                        state_d   = C_ST_SUM;
                        tx_data_d = csum_q;
                    end else begin
                        state_d    = C_ST_RD;
                        idx_d      = idx_q + 11'd1;
                        addr_d     = idx_q[9:0] + 10'd1;
                        tx_valid_d = 1'b0;
                    end
                end
            end
            C_ST_SUM: begin
                if (w_accept) begin
                    state_d    = C_ST_DONE;
                    tx_valid_d = 1'b0;
                end
            end
            C_ST_DONE: begin
                last_d  = src_q;
                state_d = C_ST_IDLE;
            end
            default: state_d = C_ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= C_ST_IDLE;
            src_q      <= C_SRC_CALIB;
            bank_q     <= 1'b0;
            last_q     <= C_SRC_DIST;
            len_q      <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            hdr_idx_q  <= '0;
            csum_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            bank_q     <= bank_d;
            last_q     <= last_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            hdr_idx_q  <= hdr_idx_d;
            csum_q     <= csum_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign o_busy         = (state_q != C_ST_IDLE);
    assign o_calib_rdaddr = (o_busy && src_q == C_SRC_CALIB) ? {bank_q, addr_q} : 11'd0;
    assign o_dist_rdaddr  = (o_busy && src_q == C_SRC_DIST)  ? {bank_q, addr_q} : 11'd0;
    assign o_overrun      = {w_dist_ovr, w_calib_ovr};
    assign tx_if.tx_valid = tx_valid_q;
    assign tx_if.tx_data  = tx_data_q;
endmodule
`default_nettype wire

// File: tb/tb_packet_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_packet_tx_arbiter : directed self-checking bench                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_packet_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        calib_make = 0, calib_bank = 0, dist_make = 0, dist_bank = 0;
    logic [15:0] calib_points = 0, dist_points = 0;
    logic [10:0] calib_rdaddr, dist_rdaddr;
    logic [7:0]  calib_rddata = 0, dist_rddata = 0;
    logic        busy;
    logic [1:0]  overrun;
    logic        toggle_en = 1'b0;

    logic [7:0]  calib_mem [0:2047];
    logic [7:0]  dist_mem  [0:2047];
    logic [7:0]  rx_q [$];
    logic [7:0]  exp_q [$];
    int          tests = 0, fails = 0;
    int          ovr_c = 0, ovr_d = 0, stall_err = 0, dist_nz = 0;
    logic [10:0] max_caddr = 0;
    logic        prev_stall = 0;
    logic [7:0]  prev_data = 0;

    packet_tx_arbiter_if tx_if ();

    packet_tx_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_calib_make(calib_make), .i_calib_pingpang(calib_bank), .i_calib_points(calib_points),
        .i_dist_make(dist_make), .i_dist_pingpang(dist_bank), .i_dist_points(dist_points),
        .o_calib_rdaddr(calib_rdaddr), .i_calib_rddata(calib_rddata),
        .o_dist_rdaddr(dist_rdaddr), .i_dist_rddata(dist_rddata),
        .tx_if(tx_if), .o_busy(busy), .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        calib_rddata <= calib_mem[calib_rdaddr];
        dist_rddata  <= dist_mem[dist_rdaddr];
    end

    always @(negedge clk) begin
        if (tx_if.tx_valid && tx_if.tx_ready) rx_q.push_back(tx_if.tx_data);
        if (prev_stall && tx_if.tx_valid && tx_if.tx_data !== prev_data) stall_err++;
        prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
        prev_data  = tx_if.tx_data;
        if (overrun[0]) ovr_c++;
        if (overrun[1]) ovr_d++;
        if (busy && calib_rdaddr > max_caddr) max_caddr = calib_rdaddr;
        if (busy && dist_rdaddr != 11'd0 && calib_rdaddr != 11'd0) dist_nz++;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) tx_if.tx_ready = ~tx_if.tx_ready;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic add_frame(input bit is_dist, input bit bank, input int points);
        int len;
        logic [7:0] cs, b;
        logic [10:0] a;
        len = points * (is_dist ? 4 : 8);
        if (len > 1024) len = 1024;
        cs = (is_dist ? 8'h02 : 8'h01) ^ 8'(len >> 8) ^ 8'(len);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(is_dist ? 8'h02 : 8'h01);
        exp_q.push_back(8'(len >> 8));
        exp_q.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            a = {bank, 10'(i)};
            b = is_dist ? dist_mem[a] : calib_mem[a];
            cs ^= b;
            exp_q.push_back(b);
        end
        exp_q.push_back(cs);
    endtask

    task automatic clear_obs();
        rx_q.delete();
        exp_q.delete();
        ovr_c = 0; ovr_d = 0; stall_err = 0; dist_nz = 0; max_caddr = 0;
    endtask

    task automatic make(input bit c, input bit cb, input int cp,
                        input bit d, input bit db, input int dp);
        @(posedge clk); #1;
        calib_make = c; calib_bank = cb; calib_points = 16'(cp);
        dist_make  = d; dist_bank  = db; dist_points  = 16'(dp);
        @(posedge clk); #1;
        calib_make = 0; dist_make = 0;
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        repeat (10) @(posedge clk);
        #2;
        chk({tag, " byte count"}, rx_q.size(), n);
    endtask

    task automatic check_stream(input string tag);
        int bad = -1;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            if (bad < 0 && rx_q[i] !== exp_q[i]) bad = i;
        tests++;
        assert (bad == -1) else begin
            fails++;
            $error("FAIL %s content: byte %0d observed 0x%0h expected 0x%0h",
                   tag, bad, rx_q[bad], exp_q[bad]);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) begin
            calib_mem[a] = 8'(a * 7 + 3);
            dist_mem[a]  = 8'(a) ^ 8'h5C;
        end
        for (int i = 0; i < 16; i++) calib_mem[11'h400 + i] = 8'(8'h10 + i);
        tx_if.tx_ready = 1'b1;

        repeat (3) @(posedge clk);
        #2;
        chk("reset tx_valid", tx_if.tx_valid, 0);
        chk("reset tx_data", tx_if.tx_data, 8'h00);
        chk("reset calib addr", calib_rdaddr, 0);
        chk("reset dist addr", dist_rdaddr, 0);
        chk("reset busy", busy, 0);
        chk("reset overrun", overrun, 0);
        #1 rst_n = 1;
        @(posedge clk); #1;

        // Calib bank 1, two dots, ready held high.
        clear_obs();
        add_frame(0, 1, 2);
        make(1, 1, 2, 0, 0, 0);
        wait_bytes("t1", 22, 400);
        check_stream("t1");
        chk("t1 max calib addr", max_caddr, 11'h40F);
        chk("t1 dist addr idle", dist_nz, 0);
        chk("t1 busy after", busy, 0);

        // Zero-length payload.
        clear_obs();
        add_frame(0, 0, 0);
        make(1, 0, 0, 0, 0, 0);
        wait_bytes("len0", 6, 200);
        check_stream("len0");
        chk("len0 checksum", rx_q.size() == 6 ? rx_q[5] : 8'hxx, 8'h01);

        // Simultaneous makes after reset; calib re-armed during its own frame.
        do_reset();
        clear_obs();
        add_frame(0, 0, 1);
        add_frame(1, 0, 1);
        add_frame(0, 0, 1);
        make(1, 0, 1, 1, 0, 1);
        repeat (6) @(posedge clk);
        make(1, 0, 1, 0, 0, 0);
        wait_bytes("tie", 14 + 10 + 14, 800);
        check_stream("tie");
        chk("tie overrun", ovr_c + ovr_d, 0);

        // Ready toggling every cycle gives the same stream as t1.
        clear_obs();
        add_frame(0, 1, 2);
        toggle_en = 1'b1;
        make(1, 1, 2, 0, 0, 0);
        wait_bytes("toggle", 22, 800);
        toggle_en = 1'b0;
        #1 tx_if.tx_ready = 1'b1;
        check_stream("toggle");
        chk("toggle stall stability", stall_err, 0);

        // Two calib makes while a dist frame is active.
        clear_obs();
        add_frame(1, 1, 1);
        add_frame(0, 0, 2);
        make(0, 0, 0, 1, 1, 1);
        repeat (3) @(posedge clk);
        make(1, 0, 3, 0, 0, 0);
        @(posedge clk);
        make(1, 0, 2, 0, 0, 0);
        wait_bytes("ovr", 10 + 22, 800);
        check_stream("ovr");
        chk("ovr calib pulses", ovr_c, 1);
        chk("ovr dist pulses", ovr_d, 0);

        // Clamp to one bank.
        clear_obs();
        add_frame(0, 0, 200);
        make(1, 0, 200, 0, 0, 0);
        wait_bytes("clamp", 1030, 6000);
        check_stream("clamp");
        chk("clamp len field", rx_q.size() > 4 ? {rx_q[3], rx_q[4]} : 16'hxxxx, 16'h0400);
        chk("clamp max addr", max_caddr, 11'h3FF);

        // Reset mid-payload.
        clear_obs();
        make(1, 1, 2, 0, 0, 0);
        for (int k = 0; k < 200 && rx_q.size() < 8; k++) begin
            @(posedge clk); #2;
        end
        chk("midrst reached payload", rx_q.size(), 8);
        rst_n = 0;
        #1;
        chk("midrst tx_valid", tx_if.tx_valid, 0);
        chk("midrst busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        clear_obs();
        repeat (20) @(posedge clk);
        #2;
        chk("midrst stays idle", busy, 0);
        chk("midrst no bytes", rx_q.size(), 0);
        add_frame(0, 1, 2);
        make(1, 1, 2, 0, 0, 0);
        wait_bytes("midrst fresh", 22, 400);
        check_stream("midrst fresh");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
